sysid_boot_checker: RTL and testbench

- Sequencer and master for the system-ID slave (1-bit address, 32-bit read data; address 0 = system ID, address 1 = build timestamp).
- After reset, and on request, reads both words, compares them against expected constants and reports pass/fail.
- Sits between the system-ID slave and the boot/status logic; a failed check holds the "image mismatch" indication for firmware and LEDs.

---
 rtl/sysid_boot_checker.sv | 160 ++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads ID and build timestamp from the sysid slave and compares them to expected constants.
// Optional periodic re-check is enabled by defining SYSID_PERIODIC_CHECK_EN.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID   = 32'd1,
    parameter logic [31:0] EXPECTED_TS   = 32'd1503996230,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned MAX_ATTEMPTS  = 3,
    parameter int unsigned PERIOD_CYCLES = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  attempt_count,
    output logic [7:0]  mismatch_count
);

    typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, COMPARE} state_t;

    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

    state_t     state, state_next;
    logic       pending;
    logic [2:0] lat_cnt;
    logic       lat_hit;
    logic       trigger;
    logic       go;
    logic       match;
    logic       retry;

`ifdef SYSID_PERIODIC_CHECK_EN
    localparam int unsigned PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    logic [PW-1:0] period_cnt;

    // Trigger is only honoured in IDLE; a wrap while busy is simply lost.
    assign trigger = (period_cnt == PW'(PERIOD_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (trigger) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end
`else
    assign trigger = 1'b0;
`endif

    assign go      = pending | start | trigger;
    assign lat_hit = (lat_cnt == LAT_LAST);
    assign match   = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
    assign retry   = (attempt_count < 4'(MAX_ATTEMPTS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        sysid_read    = 1'b0;
        sysid_address = 1'b0;
        case (state)
            IDLE: begin
                if (go) state_next = RD_ID;
            end
            RD_ID: begin
                sysid_read = 1'b1;
                state_next = (READ_LATENCY == 0) ? RD_TS : WAIT_ID;
            end
            WAIT_ID: begin
                if (lat_hit) state_next = RD_TS;
            end
            RD_TS: begin
                sysid_read    = 1'b1;
                sysid_address = 1'b1;
                state_next    = (READ_LATENCY == 0) ? COMPARE : WAIT_TS;
            end
            WAIT_TS: begin
                sysid_address = 1'b1;
                if (lat_hit) state_next = COMPARE;
            end
            COMPARE: begin
                state_next = (!match && retry) ? RD_ID : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending        <= 1'b1;
            lat_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            id_value       <= '0;
            ts_value       <= '0;
            attempt_count  <= '0;
            mismatch_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        pending       <= 1'b0;
                        attempt_count <= 4'd1;
                        busy          <= 1'b1;
                    end
                end
                RD_ID: begin
                    lat_cnt <= '0;
                    if (READ_LATENCY == 0) id_value <= sysid_readdata;
                end
                WAIT_ID: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_hit) id_value <= sysid_readdata;
                end
                RD_TS: begin
                    lat_cnt <= '0;
                    if (READ_LATENCY == 0) ts_value <= sysid_readdata;
                end
                WAIT_TS: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_hit) ts_value <= sysid_readdata;
                end
                COMPARE: begin
                    if (match) begin
                        pass <= 1'b1;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        if (mismatch_count != 8'hFF) mismatch_count <= mismatch_count + 8'd1;
                        if (retry) begin
                            attempt_count <= attempt_count + 4'd1;
                        end else begin
                            pass <= 1'b0;
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: two instances (READ_LATENCY 1 and 0) driven by a shared bench-side slave,
// checked every cycle against an offset-based transaction model, plus hand-computed directed expectations.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd1;
    localparam logic [31:0] EXP_TS = 32'd1503996230;
    localparam int          PER    = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] id_word = EXP_ID;
    logic [31:0] ts_word = EXP_TS;

    logic        addr_s [2];
    logic        read_s [2];
    logic        busy_s [2];
    logic        done_s [2];
    logic        pass_s [2];
    logic [31:0] rdata_s[2];
    logic [31:0] idv_s  [2];
    logic [31:0] tsv_s  [2];
    logic [3:0]  att_s  [2];
    logic [7:0]  mm_s   [2];
    logic [31:0] pipe   [2][8];

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned RL = (g == 0) ? 1 : 0;
        localparam int unsigned MA = (g == 0) ? 3 : 2;

        sysid_boot_checker #(
            .EXPECTED_ID  (EXP_ID),
            .EXPECTED_TS  (EXP_TS),
            .READ_LATENCY (RL),
            .MAX_ATTEMPTS (MA),
            .PERIOD_CYCLES(PER)
        ) dut (
            .clock         (clock),
            .reset         (reset),
            .start         (start),
            .sysid_address (addr_s[g]),
            .sysid_read    (read_s[g]),
            .sysid_readdata(rdata_s[g]),
            .busy          (busy_s[g]),
            .done          (done_s[g]),
            .pass          (pass_s[g]),
            .id_value      (idv_s[g]),
            .ts_value      (tsv_s[g]),
            .attempt_count (att_s[g]),
            .mismatch_count(mm_s[g])
        );

        if (RL == 0) begin : comb_rd
            assign rdata_s[g] = addr_s[g] ? ts_word : id_word;
        end else begin : reg_rd
            assign rdata_s[g] = pipe[g][RL-1];
        end
    end

    // Slave: the word is chosen at the issue cycle and delivered after the latency; filler otherwise.
    initial begin
        for (int l = 0; l < 2; l++)
            for (int k = 0; k < 8; k++) pipe[l][k] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clock);
            for (int l = 0; l < 2; l++) begin
                pipe[l][0] <= read_s[l] ? (addr_s[l] ? ts_word : id_word) : 32'hDEAD_BEEF;
                for (int k = 1; k < 8; k++) pipe[l][k] <= pipe[l][k-1];
            end
        end
    end

    function automatic int rl_of(input int l);
        return (l == 0) ? 1 : 0;
    endfunction

    function automatic int max_of(input int l);
        return (l == 0) ? 3 : 2;
    endfunction

    // Model state: offset within the current attempt, measured in cycles since RD_ID entry.
    bit          m_pending[2];
    bit          m_active [2];
    bit          m_pass   [2];
    bit          m_done   [2];
    int          m_off    [2];
    int          m_att    [2];
    int          m_mm     [2];
    int          m_per    [2];
    logic [31:0] m_id     [2];
    logic [31:0] m_ts     [2];
    logic [31:0] id_iss   [2];
    logic [31:0] ts_iss   [2];

    task automatic model_reset(input int l);
        m_pending[l] = 1'b1;
        m_active[l]  = 1'b0;
        m_pass[l]    = 1'b0;
        m_done[l]    = 1'b0;
        m_off[l]     = 0;
        m_att[l]     = 0;
        m_mm[l]      = 0;
        m_per[l]     = 0;
        m_id[l]      = '0;
        m_ts[l]      = '0;
    endtask

    task automatic model_step(input int l);
        int  rl;
        int  o;
        bit  trig;
        bit  ok;
        rl = rl_of(l);
`ifdef SYSID_PERIODIC_CHECK_EN
        trig     = (m_per[l] == PER - 1);
        m_per[l] = trig ? 0 : m_per[l] + 1;
`else
        trig = 1'b0;
`endif
        m_done[l] = 1'b0;
        if (!m_active[l]) begin
            if (m_pending[l] || start || trig) begin
                m_active[l]  = 1'b1;
                m_off[l]     = 0;
                m_att[l]     = 1;
                m_pending[l] = 1'b0;
            end
        end else begin
            o = m_off[l];
            if (o == 0)          id_iss[l] = id_word;
            if (o == rl)         m_id[l]   = id_iss[l];
            if (o == 1 + rl)     ts_iss[l] = ts_word;
            if (o == 1 + 2 * rl) m_ts[l]   = ts_iss[l];
            if (o == 2 + 2 * rl) begin
                ok = (m_id[l] == EXP_ID) && (m_ts[l] == EXP_TS);
                if (!ok && m_mm[l] < 255) m_mm[l] = m_mm[l] + 1;
                if (ok || m_att[l] >= max_of(l)) begin
                    m_pass[l]   = ok;
                    m_done[l]   = 1'b1;
                    m_active[l] = 1'b0;
                end else begin
                    m_att[l] = m_att[l] + 1;
                    m_off[l] = 0;
                end
            end else begin
                m_off[l] = o + 1;
            end
        end
    endtask

    initial begin
        for (int l = 0; l < 2; l++) model_reset(l);
        forever begin
            @(posedge clock or posedge reset);
            for (int l = 0; l < 2; l++) begin
                if (reset) model_reset(l);
                else       model_step(l);
            end
        end
    end

    task automatic check(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s lane%0d t=%0t: got %0d (0x%08h), required %0d (0x%08h)", name, l, $time, act, act, exp, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            for (int l = 0; l < 2; l++) begin
                int  rl;
                int  o;
                bit  act;
                rl  = rl_of(l);
                o   = m_off[l];
                act = m_active[l];
                check("busy",     l, 32'(busy_s[l]), 32'(act));
                check("done",     l, 32'(done_s[l]), 32'(m_done[l]));
                check("pass",     l, 32'(pass_s[l]), 32'(m_pass[l]));
                check("read",     l, 32'(read_s[l]), 32'(act && (o == 0 || o == 1 + rl)));
                check("address",  l, 32'(addr_s[l]), 32'(act && o >= 1 + rl && o <= 1 + 2 * rl));
                check("id_value", l, idv_s[l], m_id[l]);
                check("ts_value", l, tsv_s[l], m_ts[l]);
                check("attempts", l, 32'(att_s[l]), 32'(m_att[l]));
                check("mismatch", l, 32'(mm_s[l]), 32'(m_mm[l]));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int l, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (done_s[l] !== 1'b1 && n < 200);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy_s[0] || busy_s[1]) && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("idle_reached", 0, 32'(k < 200), 32'd1);
        @(negedge clock);
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_busy",  0, 32'(busy_s[0]), 32'd0);
        check("reset_read",  0, 32'(read_s[0]), 32'd0);
        reset = 1'b0;

`ifndef SYSID_PERIODIC_CHECK_EN
        // Auto-check after reset: RD_ID on the first edge, done five cycles later.
        @(negedge clock);
        check("t1_read",   0, 32'(read_s[0]), 32'd1);
        check("t1_addr",   0, 32'(addr_s[0]), 32'd0);
        wait_done(0, n);
        check("t1_cycles", 0, 32'(n), 32'd5);
        check("t1_pass",   0, 32'(pass_s[0]), 32'd1);
        check("t1_att",    0, 32'(att_s[0]), 32'd1);
        check("t1_mm",     0, 32'(mm_s[0]), 32'd0);
        check("t1_ts",     0, tsv_s[0], 32'd1503996230);
        wait_idle();

        // Wrong ID forever: all three attempts fail.
        id_word = 32'd2;
        pulse_start();
        wait_done(0, n);
        check("t2_cycles", 0, 32'(n), 32'd15);
        check("t2_pass",   0, 32'(pass_s[0]), 32'd0);
        check("t2_att",    0, 32'(att_s[0]), 32'd3);
        check("t2_mm",     0, 32'(mm_s[0]), 32'd3);
        id_word = EXP_ID;
        wait_idle();

        // Timestamp bad for the first attempt only.
        ts_word = EXP_TS ^ 32'h1;
        pulse_start();
        repeat (3) @(negedge clock);
        ts_word = EXP_TS;
        wait_done(0, n);
        check("t3_cycles", 0, 32'(n + 3), 32'd10);
        check("t3_pass",   0, 32'(pass_s[0]), 32'd1);
        check("t3_att",    0, 32'(att_s[0]), 32'd2);
        check("t3_mm",     0, 32'(mm_s[0]), 32'd4);
        wait_idle();

        // start while busy is dropped; a later start on the zero-latency lane takes three cycles.
        pulse_start();
        @(negedge clock);
        pulse_start();
        wait_done(0, n);
        check("t4_cycles", 0, 32'(n + 2), 32'd5);
        repeat (2) @(negedge clock);
        check("t4_idle",   0, 32'(busy_s[0]), 32'd0);
        pulse_start();
        wait_done(1, n);
        check("t4_rl0",    1, 32'(n), 32'd3);
        check("t4_pass",   1, 32'(pass_s[1]), 32'd1);
        wait_idle();

        // Reset during WAIT_TS clears outputs at once; the auto-check then reruns in full.
        pulse_start();
        repeat (3) @(negedge clock);
        check("t5_pre_busy", 0, 32'(busy_s[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_busy", 0, 32'(busy_s[0]), 32'd0);
        check("t5_id",   0, idv_s[0], 32'd0);
        check("t5_addr", 0, 32'(addr_s[0]), 32'd0);
        check("t5_pass", 0, 32'(pass_s[0]), 32'd0);
        check("t5_mm",   0, 32'(mm_s[0]), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t5_read", 0, 32'(read_s[0]), 32'd1);
        wait_done(0, n);
        check("t5_cycles", 0, 32'(n), 32'd5);
        check("t5_again",  0, 32'(pass_s[0]), 32'd1);
        wait_idle();
`endif

        // Randomised traffic: sporadic starts, corrupted words and resets, checked by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) id_word = ($urandom_range(0, 3) != 0) ? EXP_ID : $urandom;
            if ($urandom_range(0, 15) == 0) ts_word = ($urandom_range(0, 3) != 0) ? EXP_TS : $urandom;
            #2;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 799) == 0) reset = 1'b1;
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
